// File: rtl/pio_input_debouncer_if.sv
// Pin-side bundle for pio_input_debouncer: raw asynchronous levels in, clean levels and events out.
// The debouncer takes the slave modport; whatever drives the pins and reads the results takes master.
interface pio_input_debouncer_if #(
    parameter int unsigned WIDTH = 2
);
    logic [WIDTH-1:0] raw_in;
    logic [WIDTH-1:0] clean_out;
    logic [WIDTH-1:0] busy;
    logic [WIDTH-1:0] rise_pulse;
    logic [WIDTH-1:0] fall_pulse;

    modport master (
        output raw_in,
        input  clean_out,
        input  busy,
        input  rise_pulse,
        input  fall_pulse
    );

    modport slave (
        input  raw_in,
        output clean_out,
        output busy,
        output rise_pulse,
        output fall_pulse
    );
endinterface

// File: rtl/pio_input_debouncer.sv
// Per-channel synchronizer plus counter debounce filter feeding the Nios PIO in_port.
// Define PIO_DEBOUNCE_EDGE_OUT_EN to build the registered rise/fall pulse outputs.
module pio_input_debouncer #(
    parameter int unsigned      WIDTH           = 2,
    parameter int unsigned      SYNC_STAGES     = 2,     // legal range 2..4
    parameter int unsigned      DEBOUNCE_CYCLES = 50000, // legal range 1..2^20
    parameter logic [WIDTH-1:0] RESET_VAL       = '0
) (
    input logic                  clk,
    input logic                  reset,
    pio_input_debouncer_if.slave pio
);

    localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] DebLimit = CW'(DEBOUNCE_CYCLES);

    typedef enum logic {StStable, StPending} state_e;

    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] sync;
    state_e           state_q [WIDTH];
    state_e           state_d [WIDTH];
    logic [CW-1:0]    cnt_q [WIDTH];
    logic [CW-1:0]    cnt_d [WIDTH];
    logic [WIDTH-1:0] clean_q;
    logic [WIDTH-1:0] clean_d;
    logic [WIDTH-1:0] busy;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < SYNC_STAGES; k++) begin
                sync_q[k] <= RESET_VAL;
            end
        end else begin
            sync_q[0] <= pio.raw_in;
            for (int k = 1; k < SYNC_STAGES; k++) begin
                sync_q[k] <= sync_q[k-1];
            end
        end
    end

    assign sync = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < WIDTH; i++) begin
                state_q[i] <= StStable;
                cnt_q[i]   <= '0;
            end
            clean_q <= RESET_VAL;
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
            clean_q <= clean_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        clean_d = clean_q;
        busy    = '0;
        for (int i = 0; i < WIDTH; i++) begin
            busy[i] = (state_q[i] == StPending);
            unique case (state_q[i])
                StStable: begin
                    if (sync[i] != clean_q[i]) begin
                        // A one-cycle filter accepts the new level on the first differing edge.
                        if (DEBOUNCE_CYCLES == 1) begin
                            clean_d[i] = sync[i];
                        end else begin
                            state_d[i] = StPending;
                            cnt_d[i]   = CW'(1);
                        end
                    end
                end
                StPending: begin
                    if (sync[i] == clean_q[i]) begin
                        state_d[i] = StStable;
                        cnt_d[i]   = '0;
                    end else if (cnt_q[i] + CW'(1) == DebLimit) begin
                        clean_d[i] = sync[i];
                        state_d[i] = StStable;
                        cnt_d[i]   = '0;
                    end else begin
                        cnt_d[i] = cnt_q[i] + CW'(1);
                    end
                end
                default: begin
                    state_d[i] = StStable;
                    cnt_d[i]   = '0;
                end
            endcase
        end
    end

    assign pio.clean_out = clean_q;
    assign pio.busy      = busy;

`ifdef PIO_DEBOUNCE_EDGE_OUT_EN
    logic [WIDTH-1:0] rise_q;
    logic [WIDTH-1:0] fall_q;

    // Pulses are registered from the same next-state as clean_q so they line up with it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rise_q <= '0;
            fall_q <= '0;
        end else begin
            rise_q <= clean_d & ~clean_q;
            fall_q <= ~clean_d & clean_q;
        end
    end

    assign pio.rise_pulse = rise_q;
    assign pio.fall_pulse = fall_q;
`else
    assign pio.rise_pulse = '0;
    assign pio.fall_pulse = '0;
`endif

endmodule

// File: tb/tb_pio_input_debouncer.sv
// Scoreboard bench for pio_input_debouncer: directed plan sequences followed by random pin activity.
module tb_pio_input_debouncer;

    localparam int unsigned  W  = 2;
    localparam int unsigned  SS = 2;
    localparam int unsigned  D  = 8;
    localparam logic [W-1:0] RV = '0;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    pio_input_debouncer_if #(.WIDTH(W)) pio ();

    pio_input_debouncer #(
        .WIDTH          (W),
        .SYNC_STAGES    (SS),
        .DEBOUNCE_CYCLES(D),
        .RESET_VAL      (RV)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .pio  (pio)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [W-1:0] clean;
        logic [W-1:0] busy;
        logic [W-1:0] rise;
        logic [W-1:0] fall;
    } exp_t;

    exp_t sb_q[$];
    int   checks   = 0;
    int   failures = 0;
    bit   stim_done = 1'b0;

    // Reference: pin history delayed by SS samples, and for each channel the length of the
    // current run of samples that disagree with the accepted level.
    logic [W-1:0] m_hist [SS];
    logic [W-1:0] m_clean;
    int           m_run [W];
    logic [W-1:0] m_rise;
    logic [W-1:0] m_fall;

    function automatic void model_reset();
        for (int k = 0; k < SS; k++) m_hist[k] = RV;
        for (int c = 0; c < W; c++) m_run[c] = 0;
        m_clean = RV;
        m_rise  = '0;
        m_fall  = '0;
    endfunction

    function automatic void model_edge(input logic [W-1:0] raw);
        logic [W-1:0] seen;
        seen   = m_hist[SS-1];
        m_rise = '0;
        m_fall = '0;
        for (int c = 0; c < W; c++) begin
            if (seen[c] != m_clean[c]) begin
                m_run[c] = m_run[c] + 1;
                if (m_run[c] >= D) begin
                    m_clean[c] = seen[c];
                    m_run[c]   = 0;
                    if (seen[c]) m_rise[c] = 1'b1;
                    else         m_fall[c] = 1'b1;
                end
            end else begin
                m_run[c] = 0;
            end
        end
        for (int k = SS - 1; k > 0; k--) m_hist[k] = m_hist[k-1];
        m_hist[0] = raw;
    endfunction

    function automatic exp_t model_out();
        exp_t e;
        e.clean = m_clean;
        for (int c = 0; c < W; c++) e.busy[c] = (m_run[c] != 0);
`ifdef PIO_DEBOUNCE_EDGE_OUT_EN
        e.rise = m_rise;
        e.fall = m_fall;
`else
        e.rise = '0;
        e.fall = '0;
`endif
        return e;
    endfunction

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s at %0t: actual=%b required=%b", name, $time, act, req);
        end
    endtask

    // One clock of stimulus: drive pins/reset on the falling edge, queue what the next rising
    // edge must produce.
    task automatic step(input logic [W-1:0] raw, input logic rst);
        logic was_reset;
        @(negedge clk);
        was_reset  = reset;
        pio.raw_in = raw;
        reset      = rst;
        if (rst) begin
            model_reset();
            if (!was_reset) begin
                #1;
                check("reset_async_clean", pio.clean_out, RV);
                check("reset_async_busy", pio.busy, '0);
            end
        end else begin
            model_edge(raw);
        end
        sb_q.push_back(model_out());
    endtask

    task automatic hold(input logic [W-1:0] raw, input int n);
        for (int i = 0; i < n; i++) step(raw, 1'b0);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                check("clean_out", pio.clean_out, e.clean);
                check("busy", pio.busy, e.busy);
                check("rise_pulse", pio.rise_pulse, e.rise);
                check("fall_pulse", pio.fall_pulse, e.fall);
                check("pulse_overlap", pio.rise_pulse & pio.fall_pulse, '0);
            end
        end
    end

    initial begin : stimulus
        logic [W-1:0] raw;
        int           hold_left [W];
        pio.raw_in = '0;
        model_reset();

        repeat (3) step(2'b00, 1'b1);
        hold(2'b00, 20);                 // quiet after reset
        hold(2'b01, 14);                 // ch0 rises, latency SS+D edges
        hold(2'b11, 5);                  // ch1 glitch shorter than D
        hold(2'b01, 12);
        hold(2'b00, 14);                 // ch0 back to 0
        step(2'b01, 1'b0); step(2'b00, 1'b0); step(2'b01, 1'b0);
        step(2'b01, 1'b0); step(2'b00, 1'b0); step(2'b01, 1'b0);
        hold(2'b01, 14);                 // bounce train then steady 1
        hold(2'b00, 14);
        hold(2'b11, 30);                 // both channels together
        hold(2'b00, 14);
        hold(2'b01, 7);                  // ch0 pending, count 5
        step(2'b01, 1'b1);
        step(2'b01, 1'b1);
        hold(2'b01, 14);                 // full latency restarts after reset

        raw = '0;
        for (int c = 0; c < W; c++) hold_left[c] = 0;
        for (int n = 0; n < 800; n++) begin
            for (int c = 0; c < W; c++) begin
                if (hold_left[c] == 0) begin
                    raw[c]       = ~raw[c];
                    hold_left[c] = (($urandom % 3) == 0) ? int'($urandom_range(1, 4))
                                                         : int'($urandom_range(5, 16));
                end
                hold_left[c]--;
            end
            step(raw, ($urandom_range(0, 299) == 0));
        end
        hold(raw, 16);
        stim_done = 1'b1;
    end

    initial begin : finisher
        int budget;
        budget = 0;
        while (!stim_done && budget < 20000) begin
            @(posedge clk);
            budget++;
        end
        if (!stim_done) begin
            checks++;
            failures++;
            $display("FAIL stimulus_timeout: actual=running required=done");
        end
        repeat (4) @(posedge clk);
        #2;
        checks++;
        if (sb_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: actual=%0d required=0", sb_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
